// File: rtl/sigmoid_pwl_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_pipe
//
// Three-stage pipelined piecewise-linear sigmoid / tanh evaluator for signed
// fixed-point arguments (FRAC_W fractional bits, 1.0 = 2^FRAC_W).
//
//   stage 1 : argument scaling (tanh(x) = 2*sigmoid(2x) - 1), sign/magnitude
//             split, saturation detect, segment index + remainder
//   stage 2 : table lookup of the segment base and slope, slope * remainder
//   stage 3 : interpolation, odd symmetry, output mapping for the mode
//
// The whole pipe advances on en = !out_valid || out_ready, so a stalled
// output freezes every stage and in_ready drops.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input sample valid
//   in_ready   block accepts a sample this cycle (== en)
//   in_x       signed fixed-point argument
//   in_mode    0 = sigmoid, 1 = tanh
//   in_tag     opaque sideband tag, travels with its sample
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_y      signed fixed-point result
//   out_tag    tag belonging to out_y
//   sat_cnt    saturating count of accepted samples that hit the |x| limit
// -----------------------------------------------------------------------------
module sigmoid_pwl_pipe #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 12,
    parameter int SEG_FRAC = 1,
    parameter int XMAX     = 8,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic              in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [TAG_W-1:0]  out_tag,
    output logic [15:0]       sat_cnt
);

    localparam int NSEG  = XMAX << SEG_FRAC;
    localparam int SHIFT = FRAC_W - SEG_FRAC;      // remainder width
    localparam int IDX_W = $clog2(NSEG + 1);
    localparam int A_W   = DATA_W + 1;             // holds 2*in_x and its magnitude
    localparam int B_W   = FRAC_W + 1;             // table entries reach 1.0
    localparam int P_W   = B_W + SHIFT;            // full-width slope * remainder
    localparam int Y_W   = FRAC_W + 2;

    localparam longint            SAT_LIM = longint'(XMAX) << FRAC_W;
    localparam logic [Y_W-1:0]    ONE_Y   = Y_W'(1 << FRAC_W);
    localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1 << FRAC_W);

    // tanh output spans [-1.0, +1.0], which needs a sign bit plus the 1.0 bit.
    if (FRAC_W > DATA_W - 2) begin : g_bad_frac
        $error("sigmoid_pwl_pipe: FRAC_W must not exceed DATA_W-2");
    end
    if (SEG_FRAC < 0 || SEG_FRAC >= FRAC_W) begin : g_bad_seg
        $error("sigmoid_pwl_pipe: SEG_FRAC must lie in [0, FRAC_W-1]");
    end

    // round(sigmoid(k * 2^-SEG_FRAC) * 2^FRAC_W), evaluated with integer
    // arithmetic: e^x by its Taylor series in 32-bit-fraction fixed point,
    // then sigmoid = e^x / (1 + e^x) with round-half-up division.
    function automatic logic [FRAC_W:0] sig_entry(input int k);
        longint unsigned one_q, term, e_sum, num, den, res, k_q, n_q;
        one_q = 64'd1 << 32;
        term  = one_q;
        e_sum = one_q;
        k_q   = 64'(k);
        for (int n = 1; n < 64; n++) begin
            n_q   = 64'(n);
            term  = (term * k_q) / (n_q << SEG_FRAC);
            e_sum = e_sum + term;
        end
        num = (e_sum << (FRAC_W + 1)) + one_q + e_sum;
        den = (one_q + e_sum) << 1;
        res = num / den;
        return res[FRAC_W:0];
    endfunction

    // Segment base table, NSEG+1 entries so the last segment has an end point.
    logic [B_W-1:0] lut [0:NSEG];
    for (genvar gi = 0; gi <= NSEG; gi++) begin : g_lut
        localparam logic [B_W-1:0] ENTRY = sig_entry(gi);
        assign lut[gi] = ENTRY;
    end

    // ------------------------------------------------------------------ control
    logic en;
    logic accept;
    logic s1_valid_reg, s2_valid_reg, out_valid_reg;
    logic [DATA_W-1:0] out_y_reg;
    logic [TAG_W-1:0]  out_tag_reg;
    logic [15:0]       sat_cnt_reg;

    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // ------------------------------------------------------------------ stage 1
    logic [A_W-1:0]   xe_next;
    logic [A_W-1:0]   a_next;
    logic             sign_next;
    logic             sat_next;
    logic [IDX_W-1:0] idx_next;
    logic [SHIFT-1:0] rem_next;

    always_comb begin
        // tanh(x) = 2*sigmoid(2x) - 1, so tanh mode doubles the argument.
        xe_next   = in_mode ? {in_x, 1'b0} : {in_x[DATA_W-1], in_x};
        sign_next = xe_next[A_W-1];
        // Unsigned magnitude: the most negative xe maps to 2^(A_W-1) cleanly.
        a_next    = sign_next ? (~xe_next + A_W'(1)) : xe_next;
        sat_next  = (longint'(a_next) >= SAT_LIM);
        idx_next  = '0;
        rem_next  = '0;
        if (!sat_next) begin
            idx_next = IDX_W'(a_next >> SHIFT);
            rem_next = a_next[SHIFT-1:0];
        end
    end

    logic             s1_sign_reg, s1_sat_reg, s1_mode_reg;
    logic [IDX_W-1:0] s1_idx_reg;
    logic [SHIFT-1:0] s1_rem_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // ------------------------------------------------------------------ stage 2
    logic [IDX_W-1:0] idx_p1;
    logic [B_W-1:0]   base_next;
    logic [B_W-1:0]   slope_next;
    logic [P_W-1:0]   prod_next;

    always_comb begin
        idx_p1     = s1_idx_reg + IDX_W'(1);
        base_next  = lut[s1_idx_reg];
        // sigmoid is monotone rising on x >= 0, so the slope is never negative.
        slope_next = lut[idx_p1] - lut[s1_idx_reg];
        prod_next  = P_W'(slope_next) * P_W'(s1_rem_reg);
    end

    logic             s2_sign_reg, s2_sat_reg, s2_mode_reg;
    logic [B_W-1:0]   s2_base_reg;
    logic [P_W-1:0]   s2_prod_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    // ------------------------------------------------------------------ stage 3
    logic [Y_W-1:0]    yp_next;
    logic [Y_W-1:0]    ys_next;
    logic [DATA_W-1:0] yw_next;
    logic [DATA_W-1:0] y_next;

    always_comb begin
        yp_next = s2_sat_reg ? ONE_Y
                             : Y_W'(s2_base_reg) + Y_W'(s2_prod_reg >> SHIFT);
        // sigmoid(-x) = 1 - sigmoid(x); exact, so the pair always sums to 1.0.
        ys_next = s2_sign_reg ? (ONE_Y - yp_next) : yp_next;
        yw_next = DATA_W'(ys_next);
        y_next  = s2_mode_reg ? ((yw_next << 1) - ONE_D) : yw_next;
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_tag_reg   <= '0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_y_reg   <= y_next;
                out_tag_reg <= s2_tag_reg;
            end
        end
    end

    // Datapath registers need no reset: their valid flags gate them.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign_reg <= sign_next;
            s1_sat_reg  <= sat_next;
            s1_mode_reg <= in_mode;
            s1_idx_reg  <= idx_next;
            s1_rem_reg  <= rem_next;
            s1_tag_reg  <= in_tag;

            s2_sign_reg <= s1_sign_reg;
            s2_sat_reg  <= s1_sat_reg;
            s2_mode_reg <= s1_mode_reg;
            s2_base_reg <= base_next;
            s2_prod_reg <= prod_next;
            s2_tag_reg  <= s1_tag_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_reg <= '0;
        end else if (accept && sat_next && (sat_cnt_reg != 16'hFFFF)) begin
            sat_cnt_reg <= sat_cnt_reg + 16'd1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign out_tag   = out_tag_reg;
    assign sat_cnt   = sat_cnt_reg;

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_pwl_pipe
//
// Directed vectors with hand-computed results, a reset/flush sequence, a
// mid-stream back-pressure run and a random sweep scored against a reference
// model whose segment table comes from $exp.
// -----------------------------------------------------------------------------
module tb_sigmoid_pwl_pipe;

    localparam int ONE   = 4096;
    localparam int SHIFT = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic        in_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic [3:0]  out_tag;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    sigmoid_pwl_pipe #(
        .DATA_W  (16),
        .FRAC_W  (12),
        .SEG_FRAC(1),
        .XMAX    (8),
        .TAG_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_tag  (out_tag),
        .sat_cnt  (sat_cnt)
    );

    typedef struct {
        logic [15:0] y;
        logic [3:0]  tag;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          lut_b [0:16];
    exp_t        exp_q [$];
    int          model_sat = 0;
    logic [15:0] fire_y;
    logic [3:0]  fire_tag;
    logic [3:0]  next_tag = '0;
    bit          quiet = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [15:0] x, input logic m);
        int xe;
        xe = int'($signed(x));
        if (m) xe = 2 * xe;
        return (xe < 0) ? -xe : xe;
    endfunction

    function automatic bit is_sat(input logic [15:0] x, input logic m);
        return mag_of(x, m) >= 8 * ONE;
    endfunction

    function automatic logic [15:0] ref_y(input logic [15:0] x, input logic m);
        int xe, a, i, r, yp, ys, y;
        bit neg;
        xe  = int'($signed(x));
        if (m) xe = 2 * xe;
        neg = (xe < 0);
        a   = mag_of(x, m);
        if (a >= 8 * ONE) begin
            yp = ONE;
        end else begin
            i  = a >> SHIFT;
            r  = a % (1 << SHIFT);
            yp = lut_b[i] + ((lut_b[i+1] - lut_b[i]) * r) / (1 << SHIFT);
        end
        ys = neg ? ONE - yp : yp;
        y  = m ? 2 * ys - ONE : ys;
        return y[15:0];
    endfunction

    // One clock cycle: drive on the falling edge, then score whatever transfers
    // will happen at the following rising edge.
    task automatic do_cycle(input logic r, input logic v, input logic [15:0] x,
                            input logic m, input logic [3:0] t, input logic ordy,
                            output logic acc, output logic fire);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_x      = x;
        in_mode   = m;
        in_tag    = t;
        out_ready = ordy;
        #1;
        fire = !r && out_valid && out_ready;
        if (fire) begin
            fire_y   = out_y;
            fire_tag = out_tag;
            if (!quiet) $display("OUT tag=%0d y=0x%04h", out_tag, out_y);
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("out_y", 32'(out_y), 32'(e.y));
                check_val("out_tag", 32'(out_tag), 32'(e.tag));
            end
        end
        acc = !r && in_valid && in_ready;
        if (acc) begin
            e.y   = ref_y(x, m);
            e.tag = t;
            exp_q.push_back(e);
            if (is_sat(x, m) && model_sat < 65535) model_sat++;
        end
        if (r) begin
            exp_q.delete();
            model_sat = 0;
        end
    endtask

    // Single sample through an idle pipe: acceptance, 3-cycle latency, value.
    task automatic send_check(input string name, input logic [15:0] x, input logic m,
                              input logic [15:0] exp_y, output logic [15:0] got_y);
        logic acc, fire;
        int   n;
        bit   got;
        do_cycle(1'b0, 1'b1, x, m, next_tag, 1'b1, acc, fire);
        check_val({name, "_accept"}, 32'(acc), 32'd1);
        next_tag = next_tag + 4'd1;
        got = 1'b0;
        n   = 0;
        for (int c = 0; c < 8; c++) begin
            do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, acc, fire);
            n++;
            if (fire) begin
                got = 1'b1;
                break;
            end
        end
        check_val({name, "_latency"}, got ? 32'(n) : 32'd999, 32'd3);
        got_y = got ? fire_y : 16'hDEAD;
        check_val({name, "_y"}, 32'(got_y), 32'(exp_y));
    endtask

    logic [15:0] stall_x [0:7];
    logic        acc, fire;
    logic [15:0] y_a, y_b;
    logic [15:0] held_y;
    logic [3:0]  held_tag;
    int          nf, n, dcount, sent;

    initial begin
        for (int k = 0; k <= 16; k++)
            lut_b[k] = $rtoi(4096.0 / (1.0 + $exp(-0.5 * k)) + 0.5);

        stall_x[0] = 16'h0000; stall_x[1] = 16'h0400; stall_x[2] = 16'h1000;
        stall_x[3] = 16'hF000; stall_x[4] = 16'h8000; stall_x[5] = 16'h7FFF;
        stall_x[6] = 16'h0C34; stall_x[7] = 16'hE123;

        @(posedge clk);

        // Reset held with a valid (saturating) sample offered.
        for (int c = 0; c < 2; c++) begin
            do_cycle(1'b1, 1'b1, 16'h8000, 1'b0, 4'h5, 1'b1, acc, fire);
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_sat_cnt", 32'(sat_cnt), 32'd0);
            check_val("rst_in_ready", 32'(in_ready), 32'd1);
        end
        nf = 0;
        for (int c = 0; c < 6; c++) begin
            do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, acc, fire);
            if (out_valid) nf++;
        end
        check_val("rst_no_output", 32'(nf), 32'd0);

        // Directed values.
        send_check("sig_zero",  16'h0000, 1'b0, 16'h0800, y_a);
        send_check("tanh_zero", 16'h0000, 1'b1, 16'h0000, y_a);
        send_check("sig_quarter", 16'h0400, 1'b0, 16'h08FB, y_a);
        send_check("tanh_eighth", 16'h0200, 1'b1, 16'h01F6, y_a);
        send_check("sig_one",   16'h1000, 1'b0, 16'h0BB2, y_a);
        send_check("sig_mone",  16'hF000, 1'b0, 16'h044E, y_b);
        check_val("sym_sum", 32'(y_a) + 32'(y_b), 32'h1000);
        send_check("sig_min",   16'h8000, 1'b0, 16'h0000, y_a);
        send_check("tanh_min",  16'h8000, 1'b1, 16'hF000, y_a);
        check_val("sat_cnt_two", 32'(sat_cnt), 32'd2);
        send_check("tanh_sat",  16'h4000, 1'b1, 16'h1000, y_a);
        check_val("sat_cnt_three", 32'(sat_cnt), 32'd3);

        // Reset with samples in flight: nothing may come out afterwards.
        for (int c = 0; c < 3; c++)
            do_cycle(1'b0, 1'b1, 16'h8000, 1'b0, 4'(c), 1'b1, acc, fire);
        do_cycle(1'b1, 1'b1, 16'h1000, 1'b0, 4'h9, 1'b1, acc, fire);
        nf = 0;
        for (int c = 0; c < 6; c++) begin
            do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, acc, fire);
            if (out_valid) nf++;
        end
        check_val("flush_no_output", 32'(nf), 32'd0);
        check_val("flush_sat_cnt", 32'(sat_cnt), 32'd0);

        // Back-pressure: out_ready low for 4 cycles mid-stream.
        n = 0;
        dcount = 0;
        for (int c = 0; c < 40 && dcount < 8; c++) begin
            logic ordy;
            ordy = !(c >= 6 && c < 10);
            do_cycle(1'b0, n < 8, stall_x[n % 8], n[0], 4'(n), ordy, acc, fire);
            if (acc) n++;
            if (fire) begin
                check_val("stall_order", 32'(fire_tag), 32'(dcount));
                dcount++;
            end
            if (!ordy) begin
                check_val("stall_in_ready", 32'(in_ready), 32'd0);
                if (c == 6) begin
                    held_y   = out_y;
                    held_tag = out_tag;
                end else begin
                    check_val("stall_hold_y", 32'(out_y), 32'(held_y));
                    check_val("stall_hold_tag", 32'(out_tag), 32'(held_tag));
                end
            end
        end
        check_val("stall_delivered", 32'(dcount), 32'd8);

        // Random sweep against the reference model.
        quiet = 1'b1;
        sent = 0;
        for (int c = 0; c < 30000 && sent < 10000; c++) begin
            logic [15:0] x;
            logic        m, v, ordy;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 7))
                    0: x = 16'h8000;  1: x = 16'h7FFF;  2: x = 16'h0000;  3: x = 16'hFFFF;
                    4: x = 16'h4000;  5: x = 16'hC000;  6: x = 16'h3FFF;  default: x = 16'hC001;
                endcase
            end else begin
                x = 16'($urandom);
            end
            m    = 1'($urandom_range(0, 1));
            v    = ($urandom_range(0, 7) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            do_cycle(1'b0, v, x, m, next_tag, ordy, acc, fire);
            if (acc) begin
                sent++;
                next_tag = next_tag + 4'd1;
            end
        end
        check_val("sweep_sent", 32'(sent), 32'd10000);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++)
            do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, acc, fire);
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);
        check_val("sat_cnt_final", 32'(sat_cnt), 32'(model_sat));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigmoid_pwl_pipe.md
SIGMOID_PWL_PIPE -- requirements
Module: sigmoid_pwl_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: signed input/output width in bits.
REQ-002 The block SHALL have parameter FRAC_W, default 12: fractional bits, so 1.0 = 2^FRAC_W.
REQ-003 The block SHALL have parameter SEG_FRAC, default 1: segment width is 2^-SEG_FRAC (0.5 by default).
REQ-004 The block SHALL have parameter XMAX, default 8: integer |x| saturation limit; segment count NSEG = XMAX*2^SEG_FRAC (16 by default).
REQ-005 The block SHALL have parameter TAG_W, default 4: sideband tag width.
REQ-006 The block SHALL have port clk, input, 1 bit: the only clock; everything is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-010 The block SHALL have port in_x, input, DATA_W bits: signed fixed-point argument.
REQ-011 The block SHALL have port in_mode, input, 1 bit: 0 = sigmoid, 1 = tanh, held per sample.
REQ-012 The block SHALL have port in_tag, input, TAG_W bits: opaque tag, passed through unchanged.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 The block SHALL have port out_y, output, DATA_W bits: signed fixed-point result.
REQ-016 The block SHALL have port out_tag, output, TAG_W bits: tag of the sample on out_y.
REQ-017 The block SHALL have port sat_cnt, output, 16 bits: number of accepted samples whose effective |x| reached saturation.

Function
REQ-018 A transfer SHALL occur on a cycle where valid and ready are both 1; the block SHALL accept a sample when in_valid && in_ready.
REQ-019 The pipeline SHALL have 3 register stages with a global advance enable en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-020 When en = 0, all stage registers, out_y, out_tag and out_valid SHALL hold their values.
REQ-021 Latency SHALL be exactly 3 cycles from acceptance to out_valid when out_ready stays 1, with a throughput of 1 sample per cycle.
REQ-022 Stage 1 SHALL compute xe = in_x for sigmoid and xe = 2*in_x for tanh, using a width of at least DATA_W+1 bits, so no overflow occurs.
REQ-023 Stage 1 SHALL compute sign s = xe < 0 and a = |xe| in at least DATA_W+1 bits, with no wrap for the most negative in_x.
REQ-024 Stage 1 SHALL set saturated when a >= XMAX*2^FRAC_W.
REQ-025 Otherwise, stage 1 SHALL take segment index i = a >> (FRAC_W-SEG_FRAC) and remainder r = the low (FRAC_W-SEG_FRAC) bits of a.
REQ-026 The LUT SHALL hold NSEG+1 base entries b[k] = round(sigmoid(k*2^-SEG_FRAC)*2^FRAC_W), computed at elaboration by a constant function, with no hand-typed literals.
REQ-027 Stage 2 SHALL read b[i] and d = b[i+1]-b[i], and SHALL form the product p = d*r at full width.
REQ-028 Stage 3 SHALL compute yp = b[i] + (p >> (FRAC_W-SEG_FRAC)), truncating toward zero.
REQ-029 If saturated, stage 3 SHALL use yp = 2^FRAC_W instead.
REQ-030 Stage 3 SHALL apply symmetry: ys = yp when s = 0, else ys = 2^FRAC_W - yp.
REQ-031 Output SHALL be out_y = ys in sigmoid mode and out_y = 2*ys - 2^FRAC_W in tanh mode, giving range [-1.0, +1.0].
REQ-032 Both output ranges SHALL be representable for FRAC_W <= DATA_W-2, and this SHALL be an elaboration assertion.
REQ-033 xe = 0 SHALL yield exactly 0.5 for sigmoid and 0 for tanh, and sigmoid(x)+sigmoid(-x) SHALL equal exactly 2^FRAC_W for every x.
REQ-034 sat_cnt SHALL increment by 1 on each accepted sample with saturated = 1.
REQ-035 sat_cnt SHALL stick at 0xFFFF and SHALL NOT wrap.
REQ-036 in_mode and in_tag SHALL travel with their sample through all stages.
REQ-037 Samples SHALL leave in acceptance order, with no drops or duplicates under any out_ready pattern.

Reset
REQ-038 While rst = 1, every stage-valid flag, out_valid, out_y, out_tag and sat_cnt SHALL be 0, and in_ready SHALL be 1.
REQ-039 Reset mid-stream SHALL discard all in-flight samples, and no stale result SHALL appear after rst falls.
REQ-040 A sample presented while rst = 1 SHALL NOT be accepted.

Verification
REQ-041 Bench: rst high 2 cycles with in_valid = 1 -> out_valid = 0, sat_cnt = 0, in_ready = 1, and no output appears afterwards.
REQ-042 Bench: sigmoid with in_x = 0x0000 -> out_y = 0x0800 exactly 3 cycles later; tanh with in_x = 0x0000 -> out_y = 0x0000.
REQ-043 Bench: sigmoid with in_x = 0x1000 -> 0x0BB2, and in_x = 0xF000 -> 0x044E, whose sum is 0x1000.
REQ-044 Bench: in_x = 0x8000 sigmoid -> 0x0000, tanh -> 0xF000, and sat_cnt = 2; tanh with in_x = 0x4000 also saturates -> 0x1000.
REQ-045 Bench: stream 8 tagged samples with out_ready low for 4 cycles mid-stream -> in_ready low while stalled, outputs held stable, and all 8 delivered in tag order.
REQ-046 Bench: a random sweep of 10k samples against a bit-exact reference model of REQ-022 to REQ-031 -> zero mismatches.
